mp_add_ctrl: RTL and testbench



---
 rtl/mp_add_pkg.sv | 12 +
 rtl/mp_add_ctrl_rca.sv | 22 ++
 rtl/mp_add_ctrl.sv | 126 ++++++++++++
 tb/tb_mp_add_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared constants and FSM encoding for the multi-precision adder sequencer.
package mp_add_pkg;
    localparam int BYTE_W    = 8;
    localparam int MAX_WORDS = 16;
    localparam int IDX_W     = $clog2(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mp_add_ctrl_rca.sv
// rca_8bit: 8-bit ripple-carry adder, the byte datapath shared across all bytes
// of a multi-precision add.
module rca_8bit
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c_in,
    output logic [BYTE_W-1:0] s,
    output logic              c_out
);
    logic [BYTE_W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[BYTE_W];
endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add sequencer: one rca_8bit walked over WORDS bytes, LSB first.
// Optional subtract mode is enabled by defining MP_ADD_SUB_EN (adds a 'sub' port).
module mp_add_ctrl
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BYTE_W*WORDS-1:0] a,
    input  logic [BYTE_W*WORDS-1:0] b,
    input  logic                  c_in,
`ifdef MP_ADD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [BYTE_W*WORDS-1:0] s,
    output logic                  c_out
);
    localparam int W = BYTE_W * WORDS;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, s_q, s_d;
    logic             c_out_q, c_out_d;

    logic [BYTE_W-1:0] a_byte, b_byte, sum_byte;
    logic              add_co;
    logic              last_byte;

    assign a_byte    = a_q[idx_q*BYTE_W +: BYTE_W];
    assign last_byte = (idx_q == IDX_W'(WORDS-1));

`ifdef MP_ADD_SUB_EN
    logic sub_q, sub_d;
    // Subtract as a + ~b + 1: invert B bytes; the +1 is the forced initial carry.
    assign b_byte = sub_q ? ~b_q[idx_q*BYTE_W +: BYTE_W] : b_q[idx_q*BYTE_W +: BYTE_W];
`else
    assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];
`endif

    rca_8bit u_rca (
        .a    (a_byte),
        .b    (b_byte),
        .c_in (carry_q),
        .s    (sum_byte),
        .c_out(add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_out_d = c_out_q;
`ifdef MP_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = c_in;
                    s_d     = '0;
                    c_out_d = 1'b0;
`ifdef MP_ADD_SUB_EN
                    sub_d   = sub;
                    if (sub) carry_d = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                s_d[idx_q*BYTE_W +: BYTE_W] = sum_byte;
                carry_d = add_co;
                if (last_byte) begin
                    c_out_d = add_co;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
`ifdef MP_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_mp_add_ctrl.sv
// Scoreboard bench for mp_add_ctrl (WORDS=4): directed vectors, decoupled monitor.
module tb_mp_add_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, c_out;
    logic [W-1:0] s;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    mp_add_ctrl #(.WORDS(WORDS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .c_in (c_in),
`ifdef MP_ADD_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .s    (s),
        .c_out(c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with empty scoreboard at %0t", $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", 64'({c_out, s}), 64'(e));
            end
        end
    end

    // Issue one operation in the current IDLE cycle; optionally re-pulse start mid-run.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic sb, input logic [W:0] exp, input logic repulse);
        int cyc, bcnt;
        @(negedge clk);
        a = av; b = bv; c_in = ci; sub = sb; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hDEADBEEF; b = 32'h5A5A5A5A; c_in = ~ci; sub = ~sb;
        cyc = 0; bcnt = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) bcnt++;
            if (repulse && cyc == 1) begin
                a = 32'hAAAAAAAA; b = 32'h55555555; c_in = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_latency", 64'(cyc), 64'(WORDS + 1));
        chk("busy_cycles", 64'(bcnt), 64'(WORDS));
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(c_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 33'h0_00000100, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 33'h1_00000000, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 33'h1_FFFFFFFE, 1'b0);
        run_op(32'h80818283, 32'h01010101, 1'b0, 1'b0, 33'h0_81828384, 1'b0);
        // Start re-pulsed during RUN is ignored; next op starts the cycle after done.
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 33'h0_23456789, 1'b1);
        run_op(32'h00000001, 32'h00000002, 1'b1, 1'b0, 33'h0_00000004, 1'b0);

        // Abort mid-run: reset in the second RUN cycle.
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_s", 64'(s), 64'd0);
        chk("abort_cout", 64'(c_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 33'h0_80000000, 1'b0);

`ifdef MP_ADD_SUB_EN
        run_op(32'h00000005, 32'h00000003, 1'b0, 1'b1, 33'h1_00000002, 1'b0);
        run_op(32'h00000003, 32'h00000005, 1'b1, 1'b1, 33'h0_FFFFFFFE, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
